// File: rtl/baccarat_pkg.sv
// -----------------------------------------------------------------------------
// baccarat_pkg
// Shared definitions for the baccarat deal controller:
//   - state_t        : deal/evaluate/result sequence of one round
//   - NATURAL_MIN    : two-card total that ends the round immediately
//   - PLAYER_DRAW_MAX: highest two-card total on which the player draws
//   - BANKER_STAND   : banker total at or above which the banker never draws
//   - rank_value()   : card rank (0..13) to baccarat point value (0..9)
// -----------------------------------------------------------------------------
package baccarat_pkg;

    typedef enum logic [3:0] {
        P1     = 4'd0,
        D1     = 4'd1,
        P2     = 4'd2,
        D2     = 4'd3,
        EVAL1  = 4'd4,
        P3     = 4'd5,
        EVAL2  = 4'd6,
        D3     = 4'd7,
        RESULT = 4'd8
    } state_t;

    localparam logic [3:0] NATURAL_MIN     = 4'd8;
    localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;
    localparam logic [3:0] BANKER_STAND    = 4'd7;

    // Ace..9 count face value; tens, face cards and an empty slot count zero.
    function automatic logic [3:0] rank_value(input logic [3:0] rank);
        logic [3:0] value_s;
        if ((rank >= 4'd1) && (rank <= 4'd9)) begin
            value_s = rank;
        end else begin
            value_s = 4'd0;
        end
        return value_s;
    endfunction

endpackage : baccarat_pkg

// File: rtl/baccarat_banker_rule.sv
// -----------------------------------------------------------------------------
// baccarat_banker_rule
// Combinational banker third-card table, used once the player has drawn.
// Ports:
//   dscore [3:0] in  : banker two-card total (0..9)
//   pcard3 [3:0] in  : rank of the player third card (1..13, 0 = empty)
//   draw         out : 1 when the banker must take a third card
// -----------------------------------------------------------------------------
module baccarat_banker_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] v_s;
    logic       draw_s;

    // Banker draw decision from banker total and the player third-card value.
    always_comb begin
        v_s    = rank_value(pcard3);
        draw_s = 1'b0;
        if (dscore >= BANKER_STAND) begin
            draw_s = 1'b0;
        end else begin
            case (dscore)
                4'd0, 4'd1, 4'd2: draw_s = 1'b1;
                4'd3:             draw_s = (v_s != 4'd8);
                4'd4:             draw_s = (v_s >= 4'd2) && (v_s <= 4'd7);
                4'd5:             draw_s = (v_s >= 4'd4) && (v_s <= 4'd7);
                4'd6:             draw_s = (v_s == 4'd6) || (v_s == 4'd7);
                default:          draw_s = 1'b0;
            endcase
        end
    end

    assign draw = draw_s;

endmodule : baccarat_banker_rule

// File: rtl/baccarat_deal_ctrl.sv
// -----------------------------------------------------------------------------
// baccarat_deal_ctrl
// Sequences one baccarat round: deals P1, D1, P2, D2, evaluates naturals and
// third-card rules, and shows the winner until reset.
// Ports:
//   clk           in  : rising-edge clock
//   reset         in  : synchronous active-high reset (also suppresses outputs)
//   step          in  : advance request; one card dealt per cycle with step=1
//   pscore [3:0]  in  : player hand total from external score logic
//   dscore [3:0]  in  : banker hand total from external score logic
//   pcard3 [3:0]  in  : player third-card rank (0 = empty)
//   load_pcard1..3 out: one-cycle load strobes for the player card slots
//   load_dcard1..3 out: one-cycle load strobes for the banker card slots
//   player_win    out : player light (RESULT only)
//   dealer_win    out : banker light (RESULT only); both lit on a tie
//   done          out : round complete
// -----------------------------------------------------------------------------
module baccarat_deal_ctrl
    import baccarat_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win,
    output logic       dealer_win,
    output logic       done
);

    state_t state_r;
    logic   banker_draw_s;

    baccarat_banker_rule u_banker_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draw_s)
    );

    // Round state register; evaluation states advance regardless of step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= P1;
        end else begin
            case (state_r)
                P1:     state_r <= step ? D1    : P1;
                D1:     state_r <= step ? P2    : D1;
                P2:     state_r <= step ? D2    : P2;
                D2:     state_r <= step ? EVAL1 : D2;
                EVAL1: begin
                    if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
                        state_r <= RESULT;
                    end else if (pscore <= PLAYER_DRAW_MAX) begin
                        state_r <= P3;
                    end else if (dscore <= PLAYER_DRAW_MAX) begin
                        // Player stood on 6-7: banker draws on 0-5, the same cut-off.
                        state_r <= D3;
                    end else begin
                        state_r <= RESULT;
                    end
                end
                P3:     state_r <= step ? EVAL2 : P3;
                EVAL2:  state_r <= banker_draw_s ? D3 : RESULT;
                D3:     state_r <= step ? RESULT : D3;
                RESULT: state_r <= RESULT;
                default: state_r <= P1;
            endcase
        end
    end

    // Output decode from state and step; reset forces every output low.
    always_comb begin
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        player_win  = 1'b0;
        dealer_win  = 1'b0;
        done        = 1'b0;
        if (!reset) begin
            case (state_r)
                P1:     load_pcard1 = step;
                D1:     load_dcard1 = step;
                P2:     load_pcard2 = step;
                D2:     load_dcard2 = step;
                P3:     load_pcard3 = step;
                D3:     load_dcard3 = step;
                RESULT: begin
                    done       = 1'b1;
                    // >= on both sides lights both lamps on a tie.
                    player_win = (pscore >= dscore);
                    dealer_win = (dscore >= pscore);
                end
                default: done = 1'b0;
            endcase
        end else begin
            done = 1'b0;
        end
    end

endmodule : baccarat_deal_ctrl
